// File: rtl/srff_bank_arbiter.sv
// srff_bank_arbiter: round-robin write arbiter for a bank of external srff cells,
// with a switching-activity monitor on the bank outputs.
//   clk, rst_n    : clock, asynchronous active-low reset
//   en_i          : arbitration enable
//   req_i         : per-requester request, held until granted
//   req_idx_i     : target cell per requester, slice i = [i*IDX_W +: IDX_W]
//   req_op_i      : sr code per requester (00 hold, 01 reset, 10 set, 11 invalid)
//   gnt_o         : one-hot grant, combinational from req/en/pointer
//   sr_vec_o      : registered sr codes to the bank, cell k = [2k +: 2]
//   q_vec_i       : q outputs of the bank
//   clr_cnt_i     : synchronous clear of toggle count and saturation flag
//   toggle_cnt_o  : saturating count of observed q_vec bit changes
//   cnt_sat_o     : sticky, toggle count has saturated
//   err_op_o      : sticky, a granted command was invalid (op 11 or cell out of range)
module srff_bank_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_FF  = 8,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned IDX_W  = $clog2(NUM_FF)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx_i,
  input  logic [NUM_REQ*2-1:0]     req_op_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [2*NUM_FF-1:0]      sr_vec_o,
  input  logic [NUM_FF-1:0]        q_vec_i,
  input  logic                     clr_cnt_i,
  output logic [CNT_W-1:0]         toggle_cnt_o,
  output logic                     cnt_sat_o,
  output logic                     err_op_o
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned POP_W = $clog2(NUM_FF + 1);
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } mon_state_e;

  // Registers
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [2*NUM_FF-1:0] sr_q, sr_d;
  logic                err_q, err_d;
  mon_state_e          state_q, state_d;
  logic [NUM_FF-1:0]   q_prev_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;

  // Arbitration
  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] gnt_c;

  // Requesters at or above the pointer are searched first; the rest form the wrap-around.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
    assign hi_mask[i] = (32'(rr_ptr_q) <= i);
  end

  // Lowest set bit of the upper window wins, otherwise lowest set bit overall.
  always_comb begin : arb_comb
    req_hi = req_i & hi_mask;
    gnt_c  = '0;
    if (en_i) begin
      if (|req_hi) begin
        gnt_c = req_hi & (~req_hi + NUM_REQ'(1));
      end else begin
        gnt_c = req_i & (~req_i + NUM_REQ'(1));
      end
    end
  end

  assign gnt_o = gnt_c;

  // One-hot AND-OR selection of the granted requester's command and next pointer,
  // arranged bit-plane by bit-plane so every index is an elaboration constant.
  logic [1:0][NUM_REQ-1:0]       op_t;
  logic [IDX_W-1:0][NUM_REQ-1:0] idx_t;
  logic [PTR_W-1:0][NUM_REQ-1:0] nxt_t;
  logic [1:0]                    gnt_op;
  logic [IDX_W-1:0]              gnt_cell;
  logic [PTR_W-1:0]              ptr_nxt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    for (genvar b = 0; b < 2; b++) begin : g_op
      assign op_t[b][i] = req_op_i[2*i+b];
    end
    for (genvar b = 0; b < IDX_W; b++) begin : g_idx
      assign idx_t[b][i] = req_idx_i[IDX_W*i+b];
    end
    for (genvar b = 0; b < PTR_W; b++) begin : g_nxt
      assign nxt_t[b][i] = 1'(((i + 1) % NUM_REQ) >> b);
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_op_sel
    assign gnt_op[b] = |(gnt_c & op_t[b]);
  end
  for (genvar b = 0; b < IDX_W; b++) begin : g_idx_sel
    assign gnt_cell[b] = |(gnt_c & idx_t[b]);
  end
  for (genvar b = 0; b < PTR_W; b++) begin : g_ptr_sel
    assign ptr_nxt[b] = |(gnt_c & nxt_t[b]);
  end

  // Command path: invalid ops and out-of-range cells drive nothing and flag an error.
  logic any_gnt, op_bad, idx_bad, cmd_ok;

  assign any_gnt  = |gnt_c;
  assign op_bad   = (gnt_op == 2'b11);
  assign idx_bad  = (32'(gnt_cell) >= NUM_FF);
  assign cmd_ok   = any_gnt & ~op_bad & ~idx_bad;
  assign err_d    = err_q | (any_gnt & (op_bad | idx_bad));
  assign rr_ptr_d = any_gnt ? ptr_nxt : rr_ptr_q;

  for (genvar k = 0; k < NUM_FF; k++) begin : g_cell
    assign sr_d[2*k +: 2] = (cmd_ok && (gnt_cell == IDX_W'(k))) ? gnt_op : 2'b00;
  end

  // Monitor FSM next state: PRIME only captures q_vec so unknown power-up contents are not counted.
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;

  always_comb begin : mon_comb
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    pop     = POP_W'($countones(q_vec_i ^ q_prev_q));
    sum     = SUM_W'(cnt_q) + SUM_W'(pop);
    case (state_q)
      ST_PRIME: state_d = ST_RUN;
      ST_RUN: begin
        if (sum >= SUM_W'(CNT_MAX)) begin
          cnt_d = CNT_MAX;
          sat_d = 1'b1;
        end else begin
          cnt_d = CNT_W'(sum);
        end
      end
      default: state_d = ST_PRIME;
    endcase
    // Clear wins over accumulation; toggles seen this cycle are discarded.
    if (clr_cnt_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      sr_q     <= '0;
      err_q    <= 1'b0;
      state_q  <= ST_PRIME;
      q_prev_q <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      sr_q     <= sr_d;
      err_q    <= err_d;
      state_q  <= state_d;
      q_prev_q <= q_vec_i;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
    end
  end

  assign sr_vec_o     = sr_q;
  assign err_op_o     = err_q;
  assign toggle_cnt_o = cnt_q;
  assign cnt_sat_o    = sat_q;

endmodule

// File: tb/tb_srff_bank_arbiter.sv
// Bench for srff_bank_arbiter: directed stimulus, a behavioural model of the
// arbiter/monitor checked every cycle, plus literal expectations per scenario.
module tb_srff_bank_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned NF = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = 3;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic bank_en = 1'b1;
  logic [NR-1:0] req = '0;
  logic [2:0] b_idx [NR];
  logic [1:0] b_op [NR];
  logic [NR*IW-1:0] req_idx;
  logic [NR*2-1:0] req_op;
  logic [NF-1:0] q_bank = '0;
  logic [NF-1:0] q_drv = '0;
  logic [NF-1:0] q_vec;
  logic [NR-1:0] gnt;
  logic [2*NF-1:0] sr_vec;
  logic [CW-1:0] toggle_cnt;
  logic cnt_sat, err_op;

  assign req_idx = {b_idx[3], b_idx[2], b_idx[1], b_idx[0]};
  assign req_op  = {b_op[3], b_op[2], b_op[1], b_op[0]};
  assign q_vec   = bank_en ? q_bank : q_drv;

  srff_bank_arbiter #(.NUM_REQ(NR), .NUM_FF(NF), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .req_i(req), .req_idx_i(req_idx),
    .req_op_i(req_op), .gnt_o(gnt), .sr_vec_o(sr_vec), .q_vec_i(q_vec),
    .clr_cnt_i(clr), .toggle_cnt_o(toggle_cnt), .cnt_sat_o(cnt_sat), .err_op_o(err_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  // Model state
  int m_ptr = 0;
  logic [2*NF-1:0] m_sr = '0;
  int m_cnt = 0;
  bit m_sat = 1'b0;
  bit m_err = 1'b0;
  bit m_prime = 1'b1;
  logic [NF-1:0] m_qprev = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Round-robin choice from the current inputs: first requester at or after the pointer.
  function automatic int exp_gidx();
    if (!en) return -1;
    for (int k = 0; k < int'(NR); k++) begin
      int j;
      j = (m_ptr + k) % int'(NR);
      if (req[j]) return j;
    end
    return -1;
  endfunction

  // Behavioural model plus the external srff bank (bank captures the pre-edge sr codes).
  always @(posedge clk or negedge rst_n) begin : model
    int g, n, sum, idx;
    logic [1:0] op;
    if (!rst_n) begin
      m_ptr = 0; m_sr = '0; m_cnt = 0; m_sat = 1'b0; m_err = 1'b0; m_prime = 1'b1;
    end else begin
      for (int k = 0; k < int'(NF); k++) begin
        logic [1:0] c;
        c = 2'(sr_vec >> (2 * k));
        if (c == 2'b10) q_bank[k] <= 1'b1;
        else if (c == 2'b01) q_bank[k] <= 1'b0;
      end
      g = exp_gidx();
      m_sr = '0;
      if (g >= 0) begin
        op  = 2'(req_op >> (2 * g));
        idx = int'(3'(req_idx >> (3 * g)));
        m_ptr = (g + 1) % int'(NR);
        if (op == 2'b11 || idx >= int'(NF)) m_err = 1'b1;
        else m_sr = (2*NF)'(op) << (2 * idx);
      end
      if (clr) begin
        m_cnt = 0; m_sat = 1'b0;
      end else if (!m_prime) begin
        n = $countones(q_vec ^ m_qprev);
        sum = m_cnt + n;
        if (sum >= CMAX) begin
          m_cnt = CMAX; m_sat = 1'b1;
        end else begin
          m_cnt = sum;
        end
      end
      m_prime = 1'b0;
      m_qprev = q_vec;
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin : compare
    int g;
    logic [NR-1:0] eg;
    if (rst_n && mon_on) begin
      g = exp_gidx();
      eg = (g < 0) ? '0 : NR'(1 << g);
      chk("gnt", 32'(gnt), 32'(eg));
      chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      chk("sr_vec", 32'(sr_vec), 32'(m_sr));
      chk("toggle_cnt", 32'(toggle_cnt), 32'(m_cnt));
      chk("cnt_sat", 32'(cnt_sat), 32'(m_sat));
      chk("err_op", 32'(err_op), 32'(m_err));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : directed
    int t5exp [6];
    t5exp = '{3, 6, 9, 12, 15, 15};
    for (int k = 0; k < int'(NR); k++) begin
      b_idx[k] = '0;
      b_op[k]  = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sr_vec", 32'(sr_vec), 32'h0);
    chk("rst_cnt", 32'(toggle_cnt), 32'h0);
    chk("rst_sat", 32'(cnt_sat), 32'h0);
    chk("rst_err", 32'(err_op), 32'h0);
    rst_n = 1'b1;
    mon_on = 1'b1;
    step();

    // T1: single set of cell 3
    en = 1'b1; b_idx[0] = 3'd3; b_op[0] = 2'b10; req = 4'b0001;
    @(negedge clk); chk("t1_gnt", 32'(gnt), 32'h1);
    step(); req = 4'b0000;
    @(negedge clk); chk("t1_sr_vec", 32'(sr_vec), 32'h0080);
    step();
    @(negedge clk); chk("t1_q3", 32'(q_vec[3]), 32'h1);

    // Park the pointer at 0 with a hold command from requester 3
    step(); b_idx[3] = 3'd7; b_op[3] = 2'b00; req = 4'b1000;
    step();

    // T2: all requesting, fair rotation
    b_idx[0] = 3'd0; b_op[0] = 2'b10;
    b_idx[1] = 3'd1; b_op[1] = 2'b10;
    b_idx[2] = 3'd3; b_op[2] = 2'b01;
    b_idx[3] = 3'd7; b_op[3] = 2'b10;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); chk($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(1 << (k % 4)));
      step();
    end

    // T3: enable gating
    en = 1'b0; req = 4'b0110;
    @(negedge clk); chk("t3_gnt_off", 32'(gnt), 32'h0);
    step();
    @(negedge clk); chk("t3_sr_off", 32'(sr_vec), 32'h0);
    step(); en = 1'b1;
    @(negedge clk); chk("t3_gnt_on", 32'(gnt), 32'h2);
    step(); req = 4'b0100;
    step(); req = 4'b0000;

    // T4: invalid op on cell 5
    step(); b_idx[2] = 3'd5; b_op[2] = 2'b11; req = 4'b0100;
    @(negedge clk); chk("t4_gnt", 32'(gnt), 32'h4);
    step(); req = 4'b0000;
    @(negedge clk);
    chk("t4_sr_vec", 32'(sr_vec), 32'h0);
    chk("t4_err", 32'(err_op), 32'h1);
    repeat (3) step();
    @(negedge clk); chk("t4_err_sticky", 32'(err_op), 32'h1);

    // T5: saturation of the 4-bit counter, then clear
    step(); clr = 1'b1; q_drv = q_bank; bank_en = 1'b0;
    step(); clr = 1'b0;
    @(negedge clk); chk("t5_start", 32'(toggle_cnt), 32'h0);
    for (int k = 0; k < 6; k++) begin
      q_drv = q_drv ^ 8'h07;
      step();
      @(negedge clk); chk($sformatf("t5_cnt%0d", k), 32'(toggle_cnt), 32'(t5exp[k]));
    end
    chk("t5_sat", 32'(cnt_sat), 32'h1);
    step(); clr = 1'b1;
    step(); clr = 1'b0;
    @(negedge clk);
    chk("t5_clr_cnt", 32'(toggle_cnt), 32'h0);
    chk("t5_clr_sat", 32'(cnt_sat), 32'h0);

    // T6: reset while a command is in flight, then PRIME skips the first comparison
    step(); bank_en = 1'b1; b_idx[0] = 3'd6; b_op[0] = 2'b10; req = 4'b0001;
    step(); req = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    chk("t6_sr_async", 32'(sr_vec), 32'h0);
    chk("t6_err_rst", 32'(err_op), 32'h0);
    q_drv = q_bank ^ 8'hF0;
    bank_en = 1'b0;
    step(); rst_n = 1'b1;
    step();
    @(negedge clk); chk("t6_prime", 32'(toggle_cnt), 32'h0);
    q_drv = q_drv ^ 8'h01;
    step();
    @(negedge clk); chk("t6_run", 32'(toggle_cnt), 32'h1);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
